prbs8_checker: RTL
==================

PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 SHALL have parameter ERR_THRESH, default 4, meaning bit errors within one window that force loss of lock.
REQ-002 SHALL have parameter WINDOW, default 64, meaning compared beats per error-rate window.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of the error and beat counters.
REQ-004 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port valid_i  in  1  data_i carries a stream bit this cycle.
REQ-007 SHALL have port data_i  in  1  received PRBS bit.
REQ-008 SHALL have port clear_i  in  1  synchronous clear of err_cnt_o and beat_cnt_o.
REQ-009 SHALL have port locked_o  out  1  checker is synchronised to the stream.
REQ-010 SHALL have port err_o  out  1  one-cycle pulse marking a mismatched beat.
REQ-011 SHALL have port err_cnt_o  out  CNT_WIDTH  saturating count of mismatched beats.
REQ-012 SHALL have port beat_cnt_o  out  CNT_WIDTH  saturating count of compared beats.

Function
REQ-013 SHALL check the stream of the team's 8-bit XNOR LFSR: next bit = NOT(s[7]^s[3]^s[2]^s[1]), register shifts left, new bit enters s[0].
REQ-014 SHALL implement FSM states FILL and LOCKED; the FSM and all counters advance only on cycles with valid_i=1.
REQ-015 In FILL, SHALL shift data_i into the 8-bit register and count fill beats 0..8; no comparison, err_o=0, locked_o=0.
REQ-016 On the 8th fill beat, SHALL go to LOCKED unless the resulting register is 8'hFF (XNOR lockup state), in which case SHALL restart FILL with the fill count at 0.
REQ-017 In LOCKED, SHALL compare data_i with the predicted bit and shift the predicted bit (never data_i) into the register, so an isolated error does not propagate.
REQ-018 err_o SHALL be registered: high exactly in the cycle after a mismatched LOCKED beat.
REQ-019 locked_o SHALL be registered and high from the cycle after the 8th fill beat; the first compared beat is the 9th valid beat.
REQ-020 SHALL count errors per window of WINDOW compared beats; the window counter and window error count reset when the window completes.
REQ-021 When the window error count reaches ERR_THRESH, SHALL go to FILL on that beat; locked_o drops the following cycle and the window restarts.
REQ-022 err_cnt_o and beat_cnt_o SHALL increment per mismatch / compared beat in LOCKED and saturate at all-ones.
REQ-023 clear_i SHALL zero both counters; if it coincides with an increment, clear wins.
REQ-024 clear_i SHALL NOT affect FSM state, lock, or window counters.
REQ-025 valid_i=0 cycles SHALL hold all state; err_o=0 on the following cycle.

Reset
REQ-026 rst_i SHALL asynchronously force state FILL, shift register 8'h00, fill count 0, window counters 0, err_cnt_o=0, beat_cnt_o=0, locked_o=0, err_o=0.
REQ-027 Reset asserted mid-stream SHALL discard lock; after release, resynchronisation takes 8 valid beats.

Structure
REQ-028 Polynomial taps, the lockup constant 8'hFF, and the FSM state enum SHALL live in a shared package with the LFSR generator.
REQ-029 The next-bit function SHALL be a single package function used by both generator and checker; no sub-module is required.

Verification
REQ-030 Reset, then stream from generator seed 8'h00 (bits 1,1,0,1,...) -> locked_o=1 after 8th beat, err_o never set, beat_cnt_o=100 after 108 beats.
REQ-031 While locked, flip one bit at beat 20 -> single err_o pulse on next cycle, err_cnt_o=1, locked_o stays 1, following beats match.
REQ-032 Flip 4 bits within one 64-beat window -> locked_o drops the cycle after the 4th error, relocks 8 beats later on a clean stream.
REQ-033 Feed eight 1s in FILL -> no lock, fill restarts; feed clean stream afterwards -> lock after 8 more beats.
REQ-034 Force 70000 errors with high ERR_THRESH -> err_cnt_o saturates at 16'hFFFF; clear_i pulse -> 0 next cycle, locked_o unchanged.
REQ-035 Toggle valid_i randomly, assert rst_i mid-window -> all outputs 0 immediately, relock exactly 8 valid beats after release.

Source files
------------

// File: rtl/prbs8_checker_pkg.sv
// Shared definitions for the 8-bit XNOR PRBS: taps, lockup pattern, checker
// FSM states and the next-bit / generator-step functions.
package prbs8_checker_pkg;

    // Feedback taps s[7], s[3], s[2], s[1]
    localparam logic [7:0] PRBS8_TAPS   = 8'b1000_1110;
    // All-ones is the self-sustaining state of an XNOR LFSR
    localparam logic [7:0] PRBS8_LOCKUP = 8'hFF;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic prbs8_next_bit(input logic [7:0] s);
        return ~(^(s & PRBS8_TAPS));
    endfunction

    // One generator step: shift left, new bit enters s[0]
    function automatic logic [7:0] prbs8_step(input logic [7:0] s);
        return {s[6:0], prbs8_next_bit(s)};
    endfunction

endpackage

// File: rtl/prbs8_checker.sv
// PRBS8 checker: fills an 8-bit register from the stream, then free-runs the
// LFSR and compares each incoming bit, tracking per-window error rate for lock.
module prbs8_checker
    import prbs8_checker_pkg::*;
#(
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 data_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o
);

    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int ERR_W = $clog2(ERR_THRESH + 1);

    state_e               state_reg, state_next;
    logic [7:0]           shreg_reg, shreg_next;
    logic [3:0]           fill_cnt_reg, fill_cnt_next;
    logic [WIN_W-1:0]     win_cnt_reg, win_cnt_next;
    logic [ERR_W-1:0]     win_err_reg, win_err_next;
    logic [CNT_WIDTH-1:0] err_cnt_reg, err_cnt_next;
    logic [CNT_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
    logic                 err_reg;

    logic                 pred_bit;
    logic                 compare;
    logic                 mismatch;
    logic [ERR_W-1:0]     win_err_sum;
    logic [7:0]           fill_shreg;

    assign pred_bit    = prbs8_next_bit(shreg_reg);
    assign compare     = valid_i && (state_reg == ST_LOCKED);
    assign mismatch    = compare && (data_i != pred_bit);
    // Window error count never exceeds ERR_THRESH, so the sum always fits
    assign win_err_sum = win_err_reg + ERR_W'(mismatch);
    assign fill_shreg  = {shreg_reg[6:0], data_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_FILL;
            shreg_reg    <= 8'h00;
            fill_cnt_reg <= '0;
            win_cnt_reg  <= '0;
            win_err_reg  <= '0;
            err_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            fill_cnt_reg <= fill_cnt_next;
            win_cnt_reg  <= win_cnt_next;
            win_err_reg  <= win_err_next;
            err_cnt_reg  <= err_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            err_reg      <= mismatch;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        fill_cnt_next = fill_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        win_err_next  = win_err_reg;
        if (valid_i) begin
            case (state_reg)
                ST_FILL: begin
                    shreg_next    = fill_shreg;
                    fill_cnt_next = fill_cnt_reg + 4'd1;
                    if (fill_cnt_reg == 4'd7) begin
                        fill_cnt_next = '0;
                        if (fill_shreg != PRBS8_LOCKUP)
                            state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Shift the prediction so a single bad bit cannot corrupt later beats
                    shreg_next = {shreg_reg[6:0], pred_bit};
                    if (win_err_sum == ERR_W'(ERR_THRESH)) begin
                        state_next    = ST_FILL;
                        fill_cnt_next = '0;
                        win_cnt_next  = '0;
                        win_err_next  = '0;
                    end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        win_err_next = win_err_sum;
                    end
                end
                default: state_next = ST_FILL;
            endcase
        end
    end

    always_comb begin
        err_cnt_next  = err_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        if (clear_i) begin
            err_cnt_next  = '0;
            beat_cnt_next = '0;
        end else begin
            if (compare && (beat_cnt_reg != '1))
                beat_cnt_next = beat_cnt_reg + CNT_WIDTH'(1);
            if (mismatch && (err_cnt_reg != '1))
                err_cnt_next = err_cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        locked_o   = (state_reg == ST_LOCKED);
        err_o      = err_reg;
        err_cnt_o  = err_cnt_reg;
        beat_cnt_o = beat_cnt_reg;
    end

endmodule
